// File: rtl/qdr_multiport_arb_if.sv
// Client and controller bundle for qdr_multiport_arb.
// slave = arbiter side, master = client/controller side.
interface qdr_multiport_arb_if #(
  parameter int NUM_PORTS      = 4,
  parameter int QDR_ADDR_WIDTH = 32,
  parameter int QDR_DATA_WIDTH = 18,
  parameter int QDR_BW_WIDTH   = 2
);
  logic [NUM_PORTS*QDR_ADDR_WIDTH-1:0]   port_addr;
  logic [NUM_PORTS-1:0]                  port_wr_strb;
  logic [NUM_PORTS*2*QDR_DATA_WIDTH-1:0] port_wr_data;
  logic [NUM_PORTS*2*QDR_BW_WIDTH-1:0]   port_wr_be;
  logic [NUM_PORTS-1:0]                  port_rd_strb;
  logic [NUM_PORTS-1:0]                  port_ack;
  logic [2*QDR_DATA_WIDTH-1:0]           port_rd_data;
  logic [NUM_PORTS-1:0]                  port_rd_dvld;
  logic [QDR_ADDR_WIDTH-1:0]             master_addr;
  logic                                  master_wr_strb;
  logic [2*QDR_DATA_WIDTH-1:0]           master_wr_data;
  logic [2*QDR_BW_WIDTH-1:0]             master_wr_be;
  logic                                  master_rd_strb;
  logic [2*QDR_DATA_WIDTH-1:0]           master_rd_data;
  logic                                  master_rd_dvld;
  logic                                  tag_err;

  modport slave (
    input  port_addr, port_wr_strb, port_wr_data,
    input  port_wr_be, port_rd_strb,
    input  master_rd_data, master_rd_dvld,
    output port_ack, port_rd_data, port_rd_dvld,
    output master_addr, master_wr_strb, master_wr_data,
    output master_wr_be, master_rd_strb, tag_err
  );

  modport master (
    output port_addr, port_wr_strb, port_wr_data,
    output port_wr_be, port_rd_strb,
    output master_rd_data, master_rd_dvld,
    input  port_ack, port_rd_data, port_rd_dvld,
    input  master_addr, master_wr_strb, master_wr_data,
    input  master_wr_be, master_rd_strb, tag_err
  );
endinterface

// File: rtl/qdr_multiport_arb.sv
// Round-robin QDR port arbiter with burst hold and read-tag FIFO.
// Define QDR_ARB_STATS_EN to add per-port grant counters.
module qdr_multiport_arb #(
  parameter int NUM_PORTS      = 4,
  parameter int QDR_ADDR_WIDTH = 32,
  parameter int QDR_DATA_WIDTH = 18,
  parameter int QDR_BW_WIDTH   = 2,
  parameter int TAG_DEPTH      = 16,
  parameter int BURST_MAX      = 1
) (
  input  logic qdr_clk,
  input  logic qdr_rst,
`ifdef QDR_ARB_STATS_EN
  input  logic [2:0]  stat_sel,
  output logic [31:0] stat_count,
`endif
  qdr_multiport_arb_if.slave bus
);
  localparam int AW  = QDR_ADDR_WIDTH;
  localparam int DW  = 2*QDR_DATA_WIDTH;
  localparam int BW  = 2*QDR_BW_WIDTH;
  localparam int TW  = $clog2(NUM_PORTS);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = $clog2(BURST_MAX + 1);

  typedef logic [TW-1:0] idx_t;

  idx_t                 last;
  idx_t                 gnt_idx;
  logic                 gnt_vld;
  logic [BCW-1:0]       burst_cnt;
  logic [NUM_PORTS-1:0] elig;
  logic                 tag_room;
  logic                 hold;
  idx_t                 tags [TAG_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;

  assign tag_room = count < CW'(TAG_DEPTH);
  assign elig = bus.port_wr_strb
              | (bus.port_rd_strb & {NUM_PORTS{tag_room}});

  // burst_cnt is 0 only straight after reset: no hold then
  assign hold = elig[last] && (burst_cnt != '0)
             && (int'(burst_cnt) < BURST_MAX);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last;
    if (hold) begin
      gnt_vld = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        if (!gnt_vld && elig[(int'(last) + k) % NUM_PORTS]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx_t'((int'(last) + k) % NUM_PORTS);
        end
      end
    end
    if (qdr_rst) gnt_vld = 1'b0;
  end

  assign push = gnt_vld & bus.port_rd_strb[gnt_idx];
  assign pop  = bus.master_rd_dvld & (count != '0) & ~qdr_rst;

  always_comb begin
    bus.port_ack     = '0;
    bus.port_rd_dvld = '0;
    if (gnt_vld) bus.port_ack[gnt_idx] = 1'b1;
    if (pop) bus.port_rd_dvld[tags[rd_ptr]] = 1'b1;
  end

  assign bus.master_addr    = bus.port_addr[int'(gnt_idx)*AW +: AW];
  assign bus.master_wr_data = bus.port_wr_data[int'(gnt_idx)*DW +: DW];
  assign bus.master_wr_be   = bus.port_wr_be[int'(gnt_idx)*BW +: BW];
  assign bus.master_wr_strb = gnt_vld & bus.port_wr_strb[gnt_idx];
  assign bus.master_rd_strb = push;
  assign bus.port_rd_data   = bus.master_rd_data;

  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst) begin
      last        <= idx_t'(NUM_PORTS - 1);
      burst_cnt   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus.tag_err <= 1'b0;
    end else begin
      if (gnt_vld) begin
        if (gnt_idx == last) begin
          if (int'(burst_cnt) < BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
        end else begin
          last      <= gnt_idx;
          burst_cnt <= BCW'(1);
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (bus.master_rd_dvld && count == '0) bus.tag_err <= 1'b1;
    end
  end

  always_ff @(posedge qdr_clk) begin
    if (push) tags[wr_ptr] <= gnt_idx;
  end

`ifdef QDR_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_PORTS];
  logic [31:0] sel_val;

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (stat_sel == 3'(i)) sel_val = grant_cnt[i];
    end
  end

  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst) begin
      for (int i = 0; i < NUM_PORTS; i++) grant_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt_vld && gnt_idx == idx_t'(i) && grant_cnt[i] != '1)
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
      stat_count <= sel_val;
    end
  end
`endif

endmodule

// File: tb/tb_qdr_multiport_arb.sv
// Scoreboard bench for qdr_multiport_arb: dut_a uses defaults,
// dut_b uses BURST_MAX=2 and TAG_DEPTH=4.
module tb_qdr_multiport_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 18;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  qdr_multiport_arb_if #(N, AW, DW, BW) ia ();
  qdr_multiport_arb_if #(N, AW, DW, BW) ib ();

`ifdef QDR_ARB_STATS_EN
  logic [2:0]  sel_a = 3'd0;
  logic [2:0]  sel_b = 3'd0;
  logic [31:0] cnt_a;
  logic [31:0] cnt_b;
`endif

  qdr_multiport_arb dut_a (
    .qdr_clk(clk),
    .qdr_rst(rst_a),
`ifdef QDR_ARB_STATS_EN
    .stat_sel(sel_a),
    .stat_count(cnt_a),
`endif
    .bus(ia.slave)
  );

  qdr_multiport_arb #(.BURST_MAX(2), .TAG_DEPTH(4)) dut_b (
    .qdr_clk(clk),
    .qdr_rst(rst_b),
`ifdef QDR_ARB_STATS_EN
    .stat_sel(sel_b),
    .stat_count(cnt_b),
`endif
    .bus(ib.slave)
  );

  int total = 0;
  int bad = 0;
  int exp_q[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ia.port_wr_strb = '0;
    ia.port_rd_strb = '0;
    ia.master_rd_dvld = 1'b0;
    ib.port_wr_strb = '0;
    ib.port_rd_strb = '0;
    ib.master_rd_dvld = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      ia.port_addr[i*AW +: AW] = 32'hA000_0000 + 32'(i);
      ib.port_addr[i*AW +: AW] = 32'hB000_0000 + 32'(i);
    end
    ia.port_wr_data = '0;
    ia.port_wr_be = '0;
    ia.master_rd_data = '0;
    ib.port_wr_data = '0;
    ib.port_wr_be = '0;
    ib.master_rd_data = '0;
    ia.port_wr_strb = '1;
    ia.port_rd_strb = '1;
    ia.master_rd_dvld = 1'b1;
    ib.port_wr_strb = '0;
    ib.port_rd_strb = '0;
    ib.master_rd_dvld = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    total++;
    if (ia.port_ack !== 4'b0) begin
      bad++;
      $display("FAIL rst_ack got=%b want=0000", ia.port_ack);
    end
    total++;
    if (ia.master_wr_strb !== 1'b0 || ia.master_rd_strb !== 1'b0) begin
      bad++;
      $display("FAIL rst_strb got=%b%b want=00",
               ia.master_wr_strb, ia.master_rd_strb);
    end
    total++;
    if (ia.port_rd_dvld !== 4'b0) begin
      bad++;
      $display("FAIL rst_dvld got=%b want=0000", ia.port_rd_dvld);
    end
    total++;
    if (ia.tag_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_tag_err got=%b want=0", ia.tag_err);
    end
    cyc();
    idle();
    rst_a = 1'b0;
    rst_b = 1'b0;
    cyc();
  endtask

  task automatic test_round_robin();
    int e;
    for (int k = 0; k < 8; k++) exp_q.push_back(k % 4);
    ia.port_wr_strb = 4'hf;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (ia.port_ack !== 4'(1 << e)) begin
        bad++;
        $display("FAIL rr_ack[%0d] got=%b want=%b", k, ia.port_ack, 4'(1 << e));
      end
      total++;
      if (ia.master_addr !== 32'hA000_0000 + 32'(e)
          || ia.master_wr_strb !== 1'b1) begin
        bad++;
        $display("FAIL rr_addr[%0d] got=%h want=%h", k,
                 ia.master_addr, 32'hA000_0000 + 32'(e));
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_read_order();
    int order[4] = '{2, 1, 2, 2};
    int e;
    logic [35:0] rd;
    for (int k = 0; k < 4; k++) begin
      ia.port_rd_strb = 4'(1 << order[k]);
      @(negedge clk);
      total++;
      if (ia.port_ack !== 4'(1 << order[k]) || ia.master_rd_strb !== 1'b1) begin
        bad++;
        $display("FAIL rd_issue[%0d] got=%b want=%b", k,
                 ia.port_ack, 4'(1 << order[k]));
      end
      exp_q.push_back(order[k]);
      cyc();
    end
    idle();
    repeat (6) cyc();
    for (int k = 0; k < 4; k++) begin
      rd = 36'h5_0000_0000 + 36'(k * 17);
      ia.master_rd_data = rd;
      ia.master_rd_dvld = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (ia.port_rd_dvld !== 4'(1 << e)) begin
        bad++;
        $display("FAIL rd_route[%0d] got=%b want=%b", k,
                 ia.port_rd_dvld, 4'(1 << e));
      end
      total++;
      if (ia.port_rd_data !== rd) begin
        bad++;
        $display("FAIL rd_data[%0d] got=%h want=%h", k, ia.port_rd_data, rd);
      end
      cyc();
    end
    idle();
    @(negedge clk);
    total++;
    if (ia.tag_err !== 1'b0) begin
      bad++;
      $display("FAIL rd_no_err got=%b want=0", ia.tag_err);
    end
    cyc();
  endtask

  task automatic test_dual_and_err();
    ia.port_wr_strb = 4'b0001;
    ia.port_rd_strb = 4'b0001;
    @(negedge clk);
    total++;
    if (ia.port_ack !== 4'b0001 || ia.master_wr_strb !== 1'b1
        || ia.master_rd_strb !== 1'b1) begin
      bad++;
      $display("FAIL dual_grant got=%b/%b%b want=0001/11", ia.port_ack,
               ia.master_wr_strb, ia.master_rd_strb);
    end
    cyc();
    idle();
    cyc();
    ia.master_rd_dvld = 1'b1;
    @(negedge clk);
    total++;
    if (ia.port_rd_dvld !== 4'b0001) begin
      bad++;
      $display("FAIL dual_pop got=%b want=0001", ia.port_rd_dvld);
    end
    cyc();
    @(negedge clk);
    total++;
    if (ia.port_rd_dvld !== 4'b0000 || ia.tag_err !== 1'b0) begin
      bad++;
      $display("FAIL dual_one_tag got=%b err=%b want=0000 err=0",
               ia.port_rd_dvld, ia.tag_err);
    end
    cyc();
    idle();
    @(negedge clk);
    total++;
    if (ia.tag_err !== 1'b1) begin
      bad++;
      $display("FAIL dual_err_set got=%b want=1", ia.tag_err);
    end
    cyc();
  endtask

  task automatic test_orphan_dvld();
    rst_a = 1'b1;
    cyc();
    rst_a = 1'b0;
    cyc();
    ia.master_rd_dvld = 1'b1;
    @(negedge clk);
    total++;
    if (ia.port_rd_dvld !== 4'b0 || ia.tag_err !== 1'b0) begin
      bad++;
      $display("FAIL orphan_cycle got=%b err=%b want=0000 err=0",
               ia.port_rd_dvld, ia.tag_err);
    end
    cyc();
    idle();
    repeat (2) cyc();
    @(negedge clk);
    total++;
    if (ia.tag_err !== 1'b1) begin
      bad++;
      $display("FAIL orphan_sticky got=%b want=1", ia.tag_err);
    end
    cyc();
  endtask

  task automatic test_reset_discard();
    rst_a = 1'b1;
    cyc();
    rst_a = 1'b0;
    ia.port_rd_strb = 4'b1000;
    cyc();
    idle();
    rst_a = 1'b1;
    @(negedge clk);
    total++;
    if (ia.tag_err !== 1'b0) begin
      bad++;
      $display("FAIL disc_rst got=%b want=0", ia.tag_err);
    end
    cyc();
    rst_a = 1'b0;
    cyc();
    ia.master_rd_dvld = 1'b1;
    @(negedge clk);
    total++;
    if (ia.port_rd_dvld !== 4'b0) begin
      bad++;
      $display("FAIL disc_dvld got=%b want=0000", ia.port_rd_dvld);
    end
    cyc();
    idle();
    @(negedge clk);
    total++;
    if (ia.tag_err !== 1'b1) begin
      bad++;
      $display("FAIL disc_err got=%b want=1", ia.tag_err);
    end
    cyc();
  endtask

  task automatic test_burst();
    int e;
    int seq[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    for (int k = 0; k < 8; k++) exp_q.push_back(seq[k]);
    ib.port_wr_strb = 4'hf;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (ib.port_ack !== 4'(1 << e)) begin
        bad++;
        $display("FAIL burst_ack[%0d] got=%b want=%b", k,
                 ib.port_ack, 4'(1 << e));
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_tag_full();
    ib.port_rd_strb = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (ib.port_ack !== 4'b0010) begin
        bad++;
        $display("FAIL full_fill[%0d] got=%b want=0010", k, ib.port_ack);
      end
      cyc();
    end
    ib.port_rd_strb = 4'b0001;
    ib.port_wr_strb = 4'b1000;
    @(negedge clk);
    total++;
    if (ib.port_ack !== 4'b1000) begin
      bad++;
      $display("FAIL full_wr_wins got=%b want=1000", ib.port_ack);
    end
    cyc();
    ib.port_wr_strb = 4'b0000;
    @(negedge clk);
    total++;
    if (ib.port_ack !== 4'b0000) begin
      bad++;
      $display("FAIL full_rd_blocked got=%b want=0000", ib.port_ack);
    end
    cyc();
    ib.master_rd_dvld = 1'b1;
    @(negedge clk);
    total++;
    if (ib.port_ack !== 4'b0000 || ib.port_rd_dvld !== 4'b0010) begin
      bad++;
      $display("FAIL full_pop got=%b/%b want=0000/0010",
               ib.port_ack, ib.port_rd_dvld);
    end
    cyc();
    ib.master_rd_dvld = 1'b0;
    @(negedge clk);
    total++;
    if (ib.port_ack !== 4'b0001 || ib.master_rd_strb !== 1'b1) begin
      bad++;
      $display("FAIL full_rd_release got=%b want=0001", ib.port_ack);
    end
    cyc();
    idle();
  endtask

`ifdef QDR_ARB_STATS_EN
  task automatic test_stats();
    rst_a = 1'b1;
    cyc();
    rst_a = 1'b0;
    ia.port_wr_strb = 4'b0010;
    repeat (5) cyc();
    idle();
    sel_a = 3'd1;
    cyc();
    @(negedge clk);
    total++;
    if (cnt_a !== 32'd5) begin
      bad++;
      $display("FAIL stat_p1 got=%0d want=5", cnt_a);
    end
    cyc();
    sel_a = 3'd5;
    cyc();
    @(negedge clk);
    total++;
    if (cnt_a !== 32'd0) begin
      bad++;
      $display("FAIL stat_oob got=%0d want=0", cnt_a);
    end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_read_order();
    test_dual_and_err();
    test_orphan_dvld();
    test_reset_discard();
    test_burst();
    test_tag_full();
`ifdef QDR_ARB_STATS_EN
    test_stats();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
